alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares a single ALU593 instance between NUM_REQ requesters, typically instructionUnit instances or a test driver.
- Arbitrates round-robin, latches the winner's operands and opcode, and sequences the ALU start/done handshake.
- Returns the 16-bit result and a done pulse to the granted requester only.
- Sits between the instruction units and ALU593; the memory-interface path is untouched.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 64, maximum cycles in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester operation request; held high until its req_done.
- req_A  in  NUM_REQ x 8  operand A per requester.
- req_B  in  NUM_REQ x 8  operand B per requester.
- req_op  in  NUM_REQ x alu_opcode_t  opcode per requester.
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- req_result  out  16  result, valid while any req_done is high; broadcast to all requesters.
- gnt  out  NUM_REQ  one-hot grant, high from ISSUE through RESP.
- start  out  1  ALU start.
- A, B  out  8 each  ALU operands.
- op  out  alu_opcode_t  ALU opcode.
- alu_done  in  1  ALU completion.
- alu_result  in  16  ALU result.
- spurious_err  out  1  one-cycle pulse when alu_done arrives outside WAIT.
- timeout_err  out  1  one-cycle pulse on watchdog abort; tied 0 without the optional feature.

Behaviour:
- Interface: one clock, clk. Reset port reset is synchronous and active-high.
- Reset: state=IDLE. start, gnt, req_done, req_result, A, B, spurious_err and timeout_err are 0. op=op_no_op (encoding 0). last_grant=NUM_REQ-1, so requester 0 wins first.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick the first set bit searching from last_grant+1 with modulo-NUM_REQ wrap.
  - Register A/B/op from the winner, set gnt, go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - start=0. A, B and op are held stable.
  - On alu_done, register alu_result into req_result and go to RESP.
- RESP:
  - req_done[gnt]=1 for one cycle; req_result stays valid that cycle.
  - last_grant is set to the granted index, then gnt clears and the FSM goes to IDLE.
- Latency: req high in IDLE at cycle 0 gives start at cycle 1. alu_done at cycle k gives req_done at cycle k+1. Next start comes no earlier than k+3.
- Fairness: a requester that still holds req after its done has lowest priority in the next arbitration. No starvation is possible.
- req dropped during ISSUE/WAIT: ignored. The operation completes and req_done still pulses. Inputs are sampled only in IDLE.
- alu_done in IDLE, ISSUE or RESP: ignored for state purposes and pulses spurious_err.
- alu_done in the same cycle as start: ignored and flagged as spurious; the ALU must respond at least one cycle later.
- Reset mid-operation: immediate return to the reset values above. No req_done is issued for the aborted operation.
- Widths: the result is passed through unmodified at 16 bits. No arithmetic is done in this block.

Optional Feature:
- Macro: ALU_ARB_TIMEOUT_EN.
- When defined: a cycle counter clears on entry to WAIT. If it reaches TIMEOUT_CYC without alu_done:
  - timeout_err pulses;
  - req_result=16'h0000;
  - go to RESP, so req_done still pulses;
  - a later stray alu_done counts as spurious.
- When undefined: WAIT persists indefinitely, timeout_err is constant 0, and no counter is synthesized.

Decomposition:
- tinyalu_pkg: alu_opcode_t (existing), a new arb_state_t enum {IDLE, ISSUE, WAIT, RESP}, and the constant ARB_MAX_REQ=8.
- One sub-module: rr_picker. It is combinational: req vector + last_grant -> one-hot winner + index, parameterized by NUM_REQ.

Test Plan:
- Single request: req=2'b01, A=8'h05, B=8'h03, op=add; ALU returns 16'h0008 after 3 cycles -> start at cycle 1, req_done=2'b01 with req_result=16'h0008 at cycle 5.
- Simultaneous requests from reset: req=2'b11 held -> grants in the order 0, 1, 0, 1; each req_done one-hot; no back-to-back repeat.
- Operand stability: change req_A[0] from 8'h11 to 8'hFF during WAIT -> A stays 8'h11 until RESP.
- Spurious done: alu_done pulse in IDLE -> spurious_err=1 for one cycle, no req_done, state stays IDLE.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> next cycle all outputs 0, no req_done; req=2'b10 then grants requester 0 first if both are requesting.
- With ALU_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: ALU never responds -> timeout_err and req_done with req_result=16'h0000 at WAIT entry+8, back in IDLE next cycle.

Source files
------------

// File: rtl/tinyalu_pkg.sv
//-----------------------------------------------------------------------------
// tinyalu_pkg
//   Shared types for the TinyALU datapath and the ALU arbiter.
//   - alu_opcode_t : ALU593 opcode encoding (op_no_op is 0)
//   - arb_state_t  : arbiter FSM states
//   - ARB_MAX_REQ  : largest supported requester count
//   - rr_wrap()    : modulo wrap for a round-robin index that may exceed n-1
//-----------------------------------------------------------------------------
package tinyalu_pkg;

    typedef enum logic [2:0] {
        op_no_op = 3'b000,
        op_add   = 3'b001,
        op_and   = 3'b010,
        op_xor   = 3'b011,
        op_mul   = 3'b100
    } alu_opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int ARB_MAX_REQ = 8;

    // Index is at most 2n-1, so a single subtraction replaces a modulo.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
//-----------------------------------------------------------------------------
// alu_arbiter_if
//   Requester-side bus of the ALU arbiter.
//   Requester -> arbiter : req, req_A, req_B, req_op
//   Arbiter -> requester : req_done (one-hot pulse), req_result (broadcast),
//                          gnt (one-hot grant)
//   modport master : requester side (instruction units / test driver)
//   modport slave  : arbiter side
//-----------------------------------------------------------------------------
interface alu_arbiter_if
    import tinyalu_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic        [NUM_REQ-1:0]      req;
    logic        [NUM_REQ-1:0][7:0] req_A;
    logic        [NUM_REQ-1:0][7:0] req_B;
    alu_opcode_t [NUM_REQ-1:0]      req_op;
    logic        [NUM_REQ-1:0]      req_done;
    logic        [15:0]             req_result;
    logic        [NUM_REQ-1:0]      gnt;

    modport master (
        output req, req_A, req_B, req_op,
        input  req_done, req_result, gnt
    );

    modport slave (
        input  req, req_A, req_B, req_op,
        output req_done, req_result, gnt
    );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
//-----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Searches req starting one position
//   after last_grant, wrapping modulo NUM_REQ, and returns the first set bit.
//   Ports:
//     req        in  NUM_REQ          request vector
//     last_grant in  clog2(NUM_REQ)   index granted most recently
//     winner     out NUM_REQ          one-hot winner (0 when nothing requested)
//     winner_idx out clog2(NUM_REQ)   binary index of the winner
//     valid      out 1                at least one request present
//-----------------------------------------------------------------------------
module rr_picker
    import tinyalu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin : pick
        logic [IDX_W-1:0] cand;
        // NOTE: every output gets a default before the search loop, so no
        // path leaves a variable unassigned and no latch is inferred.
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        // i = 1 first: the previous winner is visited last, giving it lowest
        // priority in this round.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'(rr_wrap(int'(last_grant) + i, NUM_REQ));
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
//-----------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU593 between NUM_REQ requesters. Arbitrates round-robin in
//   IDLE, latches the winner's operands/opcode, pulses start for one cycle,
//   waits for alu_done, then returns the result with a one-cycle req_done to
//   the granted requester only.
//
//   Parameters:
//     NUM_REQ     requester count (2..8)
//     TIMEOUT_CYC WAIT watchdog limit in cycles (optional feature only)
//
//   Optional feature macro: ALU_ARB_TIMEOUT_EN
//     defined   : WAIT aborts after TIMEOUT_CYC cycles, pulsing timeout_err
//                 and completing the operation with req_result = 0
//     undefined : WAIT persists until alu_done; timeout_err is constant 0
//
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   synchronous, active-high reset
//     bus          slave requester bus (req/req_A/req_B/req_op in,
//                        req_done/req_result/gnt out)
//     start        out  ALU start, high for the ISSUE cycle
//     A, B         out  ALU operands, held from grant through RESP
//     op           out  ALU opcode, held from grant through RESP
//     alu_done     in   ALU completion
//     alu_result   in   ALU result
//     spurious_err out  one-cycle pulse after alu_done seen outside WAIT
//     timeout_err  out  one-cycle pulse on watchdog abort
//-----------------------------------------------------------------------------
module alu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic         start,
    output logic [7:0]   A,
    output logic [7:0]   B,
    output alu_opcode_t  op,
    input  logic         alu_done,
    input  logic [15:0]  alu_result,
    output logic         spurious_err,
    output logic         timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("alu_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
    end

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_q;
    logic [15:0]        result_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    logic [NUM_REQ-1:0] req_done_c;
    logic               load_grant;
    logic               load_result;
    logic               timeout_fire;
    logic               finish_op;
    logic               timeout_hit;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (bus.req),
        .last_grant (last_grant),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start        = 1'b0;
        req_done_c   = '0;
        load_grant   = 1'b0;
        load_result  = 1'b0;
        timeout_fire = 1'b0;
        finish_op    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    load_grant = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (alu_done) begin
                    load_result = 1'b1;
                    state_nxt   = RESP;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                req_done_c = gnt_q;
                finish_op  = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        // NOTE: these are individual output/control flops, not a storage
        // array, so all of them are reset to give defined outputs.
        if (reset) begin
            last_grant   <= IDX_W'(NUM_REQ - 1);
            gnt_idx      <= '0;
            gnt_q        <= '0;
            result_q     <= '0;
            A            <= '0;
            B            <= '0;
            op           <= op_no_op;
            spurious_err <= 1'b0;
        end else begin
            spurious_err <= alu_done && (state != WAIT);

            // Operands are captured once at grant; later changes on the
            // requester bus are invisible to the ALU.
            if (load_grant) begin
                gnt_q   <= pick_onehot;
                gnt_idx <= pick_idx;
                A       <= bus.req_A[pick_idx];
                B       <= bus.req_B[pick_idx];
                op      <= bus.req_op[pick_idx];
            end

            if (load_result) begin
                result_q <= alu_result;
            end else if (timeout_fire) begin
                result_q <= '0;
            end

            if (finish_op) begin
                last_grant <= gnt_idx;
                gnt_q      <= '0;
            end
        end
    end

    // ------------------------------------------------------- watchdog
`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // Counter is zero on the first WAIT cycle, so expiry lands on
    // WAIT entry + TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------- bus outputs
    assign bus.req_done   = req_done_c;
    assign bus.req_result = result_q;
    assign bus.gnt        = gnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
//-----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed self-checking bench for alu_arbiter with NUM_REQ = 2 and
//   TIMEOUT_CYC = 8. Inputs change and outputs are sampled 1 time unit after
//   each rising edge. Compile with ALU_ARB_TIMEOUT_EN to cover the watchdog.
//-----------------------------------------------------------------------------
module tb_alu_arbiter;
    import tinyalu_pkg::*;

    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    alu_opcode_t op;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        spurious_err;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    alu_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .start        (start),
        .A            (A),
        .B            (B),
        .op           (op),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .spurious_err (spurious_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Advance until start is seen (state ISSUE), bounded.
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 32'(start), 32'd1);
    endtask

    // One complete transaction expected to be granted to requester who;
    // the ALU answers on the first WAIT cycle.
    task automatic run_op(input int who, input logic [15:0] res, input string tag);
        logic [NUM_REQ-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[who] = 1'b1;
        wait_start(tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_oh));
        check({tag, "_A"}, 32'(A), 32'(bus.req_A[who]));
        tick();
        alu_done   = 1'b1;
        alu_result = res;
        tick();
        alu_done = 1'b0;
        check({tag, "_done"}, 32'(bus.req_done), 32'(exp_oh));
        check({tag, "_result"}, 32'(bus.req_result), 32'(res));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset      = 1'b1;
        alu_done   = 1'b0;
        alu_result = '0;
        bus.req    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_A[i]  = '0;
            bus.req_B[i]  = '0;
            bus.req_op[i] = op_no_op;
        end
        tick();
        do_reset();

        // ---- reset state
        check("rst_start",    32'(start),          32'd0);
        check("rst_gnt",      32'(bus.gnt),        32'd0);
        check("rst_req_done", 32'(bus.req_done),   32'd0);
        check("rst_result",   32'(bus.req_result), 32'd0);
        check("rst_A",        32'(A),              32'd0);
        check("rst_B",        32'(B),              32'd0);
        check("rst_op",       32'(op),             32'(op_no_op));
        check("rst_spur",     32'(spurious_err),   32'd0);
        check("rst_tmo",      32'(timeout_err),    32'd0);

        // ---- single request: start at cycle 1, done at cycle 5
        bus.req_A[0]  = 8'h05;
        bus.req_B[0]  = 8'h03;
        bus.req_op[0] = op_add;
        bus.req       = 2'b01;                    // cycle 0
        tick();                                   // cycle 1
        check("c1_start", 32'(start),   32'd1);
        check("c1_gnt",   32'(bus.gnt), 32'h1);
        check("c1_A",     32'(A),       32'h05);
        check("c1_B",     32'(B),       32'h03);
        check("c1_op",    32'(op),      32'(op_add));
        tick();                                   // cycle 2
        check("c2_start", 32'(start), 32'd0);
        tick();                                   // cycle 3
        tick();                                   // cycle 4
        check("c4_done", 32'(bus.req_done), 32'd0);
        alu_done   = 1'b1;
        alu_result = 16'h0008;
        tick();                                   // cycle 5
        alu_done = 1'b0;
        bus.req  = 2'b00;
        check("c5_done",   32'(bus.req_done),   32'h1);
        check("c5_result", 32'(bus.req_result), 32'h0008);
        check("c5_gnt",    32'(bus.gnt),        32'h1);
        tick();                                   // cycle 6
        check("c6_done", 32'(bus.req_done), 32'd0);
        check("c6_gnt",  32'(bus.gnt),      32'd0);

        // ---- simultaneous requests from reset: 0,1,0,1
        do_reset();
        bus.req_A[0]  = 8'hA0;
        bus.req_A[1]  = 8'hB1;
        bus.req_op[0] = op_xor;
        bus.req_op[1] = op_and;
        bus.req       = 2'b11;
        run_op(0, 16'h1001, "rr0");
        run_op(1, 16'h2002, "rr1");
        run_op(0, 16'h3003, "rr2");
        run_op(1, 16'h4004, "rr3");
        bus.req = 2'b00;
        tick();

        // ---- operand stability and req dropped during WAIT
        do_reset();
        bus.req_A[0] = 8'h11;
        bus.req      = 2'b01;
        tick();                                   // ISSUE
        check("stab_issue_A", 32'(A), 32'h11);
        tick();                                   // WAIT
        bus.req_A[0] = 8'hFF;
        bus.req      = 2'b00;
        tick();
        check("stab_wait_A",     32'(A),     32'h11);
        check("stab_wait_start", 32'(start), 32'd0);
        alu_done   = 1'b1;
        alu_result = 16'h00AA;
        tick();                                   // RESP
        alu_done = 1'b0;
        check("stab_resp_A",  32'(A),                32'h11);
        check("stab_done",    32'(bus.req_done),     32'h1);
        check("stab_result",  32'(bus.req_result),   32'h00AA);
        tick();

        // ---- spurious done in IDLE
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("spur_idle_err",   32'(spurious_err), 32'd1);
        check("spur_idle_done",  32'(bus.req_done), 32'd0);
        check("spur_idle_start", 32'(start),        32'd0);
        tick();
        check("spur_idle_clear", 32'(spurious_err), 32'd0);
        check("spur_idle_stay",  32'(start),        32'd0);

        // ---- alu_done coincident with start
        bus.req = 2'b01;
        tick();                                   // ISSUE
        check("spur_iss_start", 32'(start), 32'd1);
        alu_done   = 1'b1;
        alu_result = 16'hDEAD;
        tick();                                   // WAIT
        alu_done = 1'b0;
        check("spur_iss_err",  32'(spurious_err), 32'd1);
        check("spur_iss_done", 32'(bus.req_done), 32'd0);
        tick();
        check("spur_iss_wait", 32'(bus.req_done), 32'd0);
        alu_done   = 1'b1;
        alu_result = 16'h0042;
        tick();                                   // RESP
        alu_done = 1'b0;
        check("spur_iss_resp",   32'(bus.req_done),   32'h1);
        check("spur_iss_result", 32'(bus.req_result), 32'h0042);
        bus.req = 2'b00;
        tick();

        // ---- reset during WAIT (last_grant was 0, so requester 1 wins)
        bus.req = 2'b10;
        wait_start("mid");
        check("mid_gnt", 32'(bus.gnt), 32'h2);
        tick();                                   // WAIT
        do_reset();
        check("mid_start",  32'(start),          32'd0);
        check("mid_gnt0",   32'(bus.gnt),        32'd0);
        check("mid_done",   32'(bus.req_done),   32'd0);
        check("mid_result", 32'(bus.req_result), 32'd0);
        check("mid_A",      32'(A),              32'd0);
        check("mid_op",     32'(op),             32'(op_no_op));
        bus.req = 2'b11;
        run_op(0, 16'h0777, "post_rst");
        bus.req = 2'b00;
        tick();

`ifdef ALU_ARB_TIMEOUT_EN
        // ---- watchdog: ALU never answers
        bus.req = 2'b01;
        wait_start("tmo");
        tick();                                   // WAIT entry
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            tick();
        end                                       // WAIT entry + 7
        check("tmo_early_done", 32'(bus.req_done), 32'd0);
        check("tmo_early_err",  32'(timeout_err),  32'd0);
        tick();                                   // WAIT entry + 8
        bus.req = 2'b00;
        check("tmo_err",    32'(timeout_err),    32'd1);
        check("tmo_done",   32'(bus.req_done),   32'h1);
        check("tmo_result", 32'(bus.req_result), 32'h0000);
        tick();
        check("tmo_idle_gnt", 32'(bus.gnt),     32'd0);
        check("tmo_err_clr",  32'(timeout_err), 32'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("tmo_stray_spur", 32'(spurious_err), 32'd1);
`else
        // ---- no watchdog: WAIT persists
        bus.req = 2'b01;
        wait_start("hold");
        tick();
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (bus.req_done != '0 || timeout_err != 1'b0) seen = 1'b1;
            end
            check("hold_no_done", 32'(seen),    32'd0);
            check("hold_gnt",     32'(bus.gnt), 32'h1);
        end
        bus.req = 2'b00;
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
